data_mem_arbiter: RTL and testbench

//  Two-requester controller in front of the byte-addressed 32-bit data memory (mem_* ports).

---
 rtl/data_mem_arb_pkg.sv | 30 +++
 rtl/data_mem_arbiter_subword_lane.sv | 42 ++++
 rtl/data_mem_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arb_pkg.sv
// Shared types and constants for the data memory arbiter.
package data_mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RMW_RD,
        WR,
        RESP
    } state_e;

    typedef logic port_id_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SIZE_HALF: bad = off[0];
            SIZE_WORD: bad = (off != 2'b00);
            SIZE_RSVD: bad = 1'b1;
            default:   bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/data_mem_arbiter_subword_lane.sv
// Byte/half lane extraction for loads and lane merge for read-modify-write stores.
module subword_lane
    import data_mem_arb_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [4:0]  shamt;
    logic [31:0] lane_mask;

    always_comb begin
        load_data = rword;
        merged    = wdata;
        shamt     = '0;
        lane_mask = '0;
        case (size)
            SIZE_BYTE: begin
                shamt     = {offset, 3'b000};
                lane_mask = 32'h0000_00ff;
                load_data = (rword >> shamt) & lane_mask;
                merged    = (rword & ~(lane_mask << shamt)) | ((wdata & lane_mask) << shamt);
            end
            SIZE_HALF: begin
                // Half accesses ignore offset[0]
                shamt     = {offset[1], 4'b0000};
                lane_mask = 32'h0000_ffff;
                load_data = (rword >> shamt) & lane_mask;
                merged    = (rword & ~(lane_mask << shamt)) | ((wdata & lane_mask) << shamt);
            end
            default: begin
                load_data = rword;
                merged    = wdata;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin two-port controller for a 32-bit data memory without byte enables.
// Optional `ALIGN_CHECK_EN rejects misaligned/reserved requests with an error response.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 65536,
    parameter bit          RST_PRIO  = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_we,
    input  logic [1:0]  req0_size,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_rdata,
    output logic        rsp0_err,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_we,
    input  logic [1:0]  req1_size,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_rdata,
    output logic        rsp1_err,
    output logic        mem_write,
    output logic        mem_read,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1);

    state_e      state_q, state_d;
    port_id_t    port_q, port_d;
    port_id_t    last_q, last_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
`ifdef ALIGN_CHECK_EN
    logic        err_q, err_d;
`endif

    logic        grant_valid;
    port_id_t    grant;
    logic        sel_we;
    logic [1:0]  sel_size;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        word_access;
    logic [31:0] eff_addr;
    logic [31:0] lane_load;
    logic [31:0] lane_merged;

    subword_lane u_lane (
        .size      (size_q),
        .offset    (addr_q[1:0]),
        .rword     (mem_rdata),
        .wdata     (wdata_q),
        .load_data (lane_load),
        .merged    (lane_merged)
    );

    always_comb begin
        grant_valid = req0_valid | req1_valid;
        // On contention the port that did not win last time is served
        if (req0_valid && req1_valid) grant = ~last_q;
        else                          grant = req1_valid;
        sel_we    = grant ? req1_we    : req0_we;
        sel_size  = grant ? req1_size  : req0_size;
        sel_addr  = grant ? req1_addr  : req0_addr;
        sel_wdata = grant ? req1_wdata : req0_wdata;

        word_access = (size_q == SIZE_WORD) || (size_q == SIZE_RSVD);
        eff_addr    = (word_access ? addr_q : {addr_q[31:2], 2'b00}) & ADDR_MASK;

        state_d = state_q;
        port_d  = port_q;
        last_d  = last_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef ALIGN_CHECK_EN
        err_d   = err_q;
`endif

        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        rsp0_rdata = '0;
        rsp1_rdata = '0;
        rsp0_err   = 1'b0;
        rsp1_err   = 1'b0;
        mem_write  = 1'b0;
        mem_read   = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        case (state_q)
            IDLE: begin
                if (grant_valid && rst_n) begin
                    req0_ready = ~grant;
                    req1_ready = grant;
                    port_d     = grant;
                    size_d     = sel_size;
                    addr_d     = sel_addr;
                    wdata_d    = sel_wdata;
                    rdata_d    = '0;
`ifdef ALIGN_CHECK_EN
                    err_d      = 1'b0;
                    if (is_misaligned(sel_size, sel_addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else
`endif
                    if (!sel_we)                                           state_d = RD;
                    else if (sel_size == SIZE_BYTE || sel_size == SIZE_HALF) state_d = RMW_RD;
                    else                                                   state_d = WR;
                end
            end
            RD: begin
                mem_read = 1'b1;
                mem_addr = eff_addr;
                rdata_d  = lane_load;
                state_d  = RESP;
            end
            RMW_RD: begin
                mem_read = 1'b1;
                mem_addr = eff_addr;
                wdata_d  = lane_merged;
                state_d  = WR;
            end
            WR: begin
                mem_write = 1'b1;
                mem_addr  = eff_addr;
                mem_wdata = wdata_q;
                state_d   = RESP;
            end
            RESP: begin
                rsp0_valid = ~port_q;
                rsp1_valid = port_q;
                rsp0_rdata = port_q ? '0 : rdata_q;
                rsp1_rdata = port_q ? rdata_q : '0;
`ifdef ALIGN_CHECK_EN
                rsp0_err   = ~port_q & err_q;
                rsp1_err   = port_q & err_q;
`endif
                last_d     = port_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            port_q  <= 1'b0;
            last_q  <= ~RST_PRIO;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef ALIGN_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            last_q  <= last_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef ALIGN_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: directed requests, queued expectations, decoupled monitor.
module tb_data_mem_arbiter;
    import data_mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req0_we = 1'b0, req1_valid = 1'b0, req1_we = 1'b0;
    logic [1:0]  req0_size = '0, req1_size = '0;
    logic [31:0] req0_addr = '0, req0_wdata = '0, req1_addr = '0, req1_wdata = '0;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic        mem_write, mem_read;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    data_mem_arbiter #(.MEM_BYTES(65536), .RST_PRIO(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we), .req0_size(req0_size),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we), .req1_size(req1_size),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .rsp1_err(rsp1_err),
        .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Simple word memory; low address bits are ignored on access
    logic [31:0] mem [0:16383];
    logic        bd_en = 1'b0;
    logic [31:0] bd_addr = '0, bd_data = '0;
    assign mem_rdata = mem[mem_addr[15:2]];
    always @(posedge clk) begin
        if (mem_write)  mem[mem_addr[15:2]] <= mem_wdata;
        else if (bd_en) mem[bd_addr[15:2]]  <= bd_data;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    int          grants[$];
    int          checks = 0;
    int          failures = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [31:0] last_rd_addr = '0;
    bit          mon_en = 1'b0;
    bit          log_grants = 1'b0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    task automatic serve(input int p);
        logic        v, er;
        logic [31:0] rd;
        exp_t        e;
        int          qs;
        v  = (p == 0) ? rsp0_valid : rsp1_valid;
        er = (p == 0) ? rsp0_err   : rsp1_err;
        rd = (p == 0) ? rsp0_rdata : rsp1_rdata;
        qs = (p == 0) ? q0.size()  : q1.size();
        if (v === 1'b1) begin
            if (qs == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp port=%0d actual=valid required=no_response", p);
            end else begin
                if (p == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                check32($sformatf("rsp%0d_rdata", p), rd, e.rdata);
                check32($sformatf("rsp%0d_err", p), {31'b0, er}, {31'b0, e.err});
                check32($sformatf("rsp%0d_cycle", p), 32'(cyc), 32'(e.due));
            end
        end else if (qs > 0) begin
            if (p == 0) e = q0[0];
            else        e = q1[0];
            if (cyc > e.due) begin
                checks++;
                failures++;
                $display("FAIL missing_rsp port=%0d actual=none required=cycle_%0d", p, e.due);
                if (p == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (mon_en) begin
            check32("one_ready", {31'b0, req0_ready & req1_ready}, 32'h0);
            check32("rd_wr_excl", {31'b0, mem_read & mem_write}, 32'h0);
            if (mem_read === 1'b1) begin
                rd_cnt++;
                last_rd_addr = mem_addr;
            end
            if (mem_write === 1'b1) wr_cnt++;
            if (log_grants) begin
                if (req0_ready === 1'b1) grants.push_back(0);
                if (req1_ready === 1'b1) grants.push_back(1);
            end
            serve(0);
            serve(1);
        end
    end

    task automatic drive(input int p, input logic we, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err,
                         input int lat, input bit expect_rsp);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        if (p == 0) begin
            req0_we = we; req0_size = size; req0_addr = addr; req0_wdata = wdata; req0_valid = 1'b1;
        end else begin
            req1_we = we; req1_size = size; req1_addr = addr; req1_wdata = wdata; req1_valid = 1'b1;
        end
        #1;
        while (((p == 0) ? req0_ready : req1_ready) !== 1'b1 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout port=%0d actual=not_accepted required=accepted", p);
        end else if (expect_rsp) begin
            e.rdata = exp_rdata;
            e.err   = exp_err;
            e.due   = cyc + lat;
            if (p == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(posedge clk);
        #1;
        if (p == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
    endtask

    task automatic poke(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        bd_addr = addr; bd_data = data; bd_en = 1'b1;
        @(posedge clk);
        #1;
        bd_en = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 30; i++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r0, w0;
        // Reset: outputs quiet even with a request pending
        rst_n = 1'b0;
        req0_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        check32("rst_ready0", {31'b0, req0_ready}, 32'h0);
        check32("rst_rsp", {30'b0, rsp0_valid, rsp1_valid}, 32'h0);
        check32("rst_mem_ctl", {30'b0, mem_read, mem_write}, 32'h0);
        check32("rst_mem_addr", mem_addr, 32'h0);
        check32("rst_mem_wdata", mem_wdata, 32'h0);
        check32("rst_rdata", rsp0_rdata | rsp1_rdata, 32'h0);
        check32("rst_err", {30'b0, rsp0_err, rsp1_err}, 32'h0);
        req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Word store then load
        drive(0, 1'b1, SIZE_WORD, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1);
        drive(0, 1'b0, SIZE_WORD, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b1);
        drain();

        // Byte store as read-modify-write
        drive(0, 1'b1, SIZE_WORD, 32'h100, 32'h11223344, 32'h0, 1'b0, 2, 1'b1);
        drain();
        r0 = rd_cnt;
        w0 = wr_cnt;
        drive(0, 1'b1, SIZE_BYTE, 32'h101, 32'h000000AB, 32'h0, 1'b0, 3, 1'b1);
        drain();
        check32("rmw_reads", 32'(rd_cnt - r0), 32'd1);
        check32("rmw_writes", 32'(wr_cnt - w0), 32'd1);
        check32("rmw_mem_word", mem[32'h100 >> 2], 32'h1122AB44);
        drive(1, 1'b0, SIZE_WORD, 32'h100, 32'h0, 32'h1122AB44, 1'b0, 2, 1'b1);

        // Sub-word loads, half store, address wrap to memory size
        poke(32'h200, 32'hCAFEF00D);
        drive(0, 1'b0, SIZE_HALF, 32'h202, 32'h0, 32'h0000CAFE, 1'b0, 2, 1'b1);
        drive(0, 1'b0, SIZE_BYTE, 32'h201, 32'h0, 32'h000000F0, 1'b0, 2, 1'b1);
        drive(1, 1'b1, SIZE_HALF, 32'h202, 32'h0000BEEF, 32'h0, 1'b0, 3, 1'b1);
        drive(1, 1'b0, SIZE_WORD, 32'h200, 32'h0, 32'hBEEFF00D, 1'b0, 2, 1'b1);
        drive(0, 1'b0, SIZE_BYTE, 32'h10203, 32'h0, 32'h000000BE, 1'b0, 2, 1'b1);
        drain();
        check32("wrap_mem_addr", last_rd_addr, 32'h200);

        // Contention right after reset: strict alternation starting with port 0
        do_reset();
        grants.delete();
        log_grants = 1'b1;
        fork
            for (int i = 0; i < 3; i++)
                drive(0, 1'b0, SIZE_WORD, 32'h200, 32'h0, 32'hBEEFF00D, 1'b0, 2, 1'b1);
            for (int j = 0; j < 3; j++)
                drive(1, 1'b0, SIZE_BYTE, 32'h201, 32'h0, 32'h000000F0, 1'b0, 2, 1'b1);
        join
        drain();
        log_grants = 1'b0;
        check32("grant_count", 32'(grants.size()), 32'd6);
        for (int k = 0; k < 6; k++)
            if (k < grants.size()) check32($sformatf("grant_%0d", k), 32'(grants[k]), 32'(k % 2));

        // Reset during RMW_RD: no write, no response, memory intact
        poke(32'h300, 32'h55667788);
        w0 = wr_cnt;
        drive(0, 1'b1, SIZE_BYTE, 32'h300, 32'h00000099, 32'h0, 1'b0, 3, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        #3;
        check32("abort_idle_outputs", {28'b0, mem_read, mem_write, rsp0_valid, rsp1_valid}, 32'h0);
        repeat (5) @(negedge clk);
        check32("abort_no_write", 32'(wr_cnt - w0), 32'd0);
        check32("abort_mem_word", mem[32'h300 >> 2], 32'h55667788);
        drive(0, 1'b0, SIZE_WORD, 32'h300, 32'h0, 32'h55667788, 1'b0, 2, 1'b1);
        drain();

        // Unaligned word load and reserved size
        r0 = rd_cnt;
`ifdef ALIGN_CHECK_EN
        drive(0, 1'b0, SIZE_WORD, 32'h103, 32'h0, 32'h0, 1'b1, 1, 1'b1);
        drive(1, 1'b0, SIZE_RSVD, 32'h200, 32'h0, 32'h0, 1'b1, 1, 1'b1);
        drain();
        check32("unaligned_reads", 32'(rd_cnt - r0), 32'd0);
`else
        drive(0, 1'b0, SIZE_WORD, 32'h103, 32'h0, 32'h1122AB44, 1'b0, 2, 1'b1);
        drain();
        check32("unaligned_reads", 32'(rd_cnt - r0), 32'd1);
        check32("unaligned_addr", last_rd_addr, 32'h103);
        drive(1, 1'b0, SIZE_RSVD, 32'h200, 32'h0, 32'hBEEFF00D, 1'b0, 2, 1'b1);
        drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
